// File: rtl/rr_mux8_arbiter.sv
// Eight-channel round-robin arbiter driving a shared 1-bit mux.
// The current owner keeps the mux for at most MAX_HOLD consecutive cycles.
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | no owner; gnt=0, busy=0, sel holds last index
// GRANT | one owner (sel); hcnt counts cycles held
module rr_mux8_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       y
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [3:0] hcnt, hcnt_n;
    logic [7:0] gnt_n;
    logic [2:0] sel_n;
    logic       busy_n;

    logic [2:0] search_start;
    logic       hit;
    logic [2:0] win;
    logic       rotate;

    // First requester at or after start, wrapping through all eight channels.
    function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] c;
        found = 1'b0;
        idx   = start;
        for (int i = 0; i < 8; i++) begin
            c = start + 3'(i);
            if (!found && r[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
        return {found, idx};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd0;
            hcnt  <= 4'd0;
            gnt   <= 8'd0;
            sel   <= 3'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hcnt  <= hcnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            busy  <= busy_n;
        end
    end

    // A release or timeout moves the pointer past the owner before searching.
    assign rotate       = (state == GRANT) && (!req[sel] || hcnt == HOLD_LAST);
    assign search_start = rotate ? sel + 3'd1 : ptr;
    assign {hit, win}   = rr_search(req, search_start);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        gnt_n   = gnt;
        sel_n   = sel;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_n = GRANT;
                    gnt_n   = 8'd1 << win;
                    sel_n   = win;
                    busy_n  = 1'b1;
                    hcnt_n  = 4'd0;
                end
            end
            GRANT: begin
                if (rotate) begin
                    ptr_n  = sel + 3'd1;
                    hcnt_n = 4'd0;
                    if (hit) begin
                        gnt_n = 8'd1 << win;
                        sel_n = win;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 8'd0;
                        busy_n  = 1'b0;
                    end
                end else begin
                    hcnt_n = hcnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 8'd0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign y = busy ? din[sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter (MAX_HOLD=4); expected values are hand-computed.
module tb_rr_mux8_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;

    int checks = 0;
    int errors = 0;

    rr_mux8_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .din (din),
        .gnt (gnt),
        .sel (sel),
        .busy(busy),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        din = 8'hff;
        req = 8'hff;
        rst = 1'b1;
        step();
        checks++;
        if ({gnt, sel, busy, y} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset gnt=%h sel=%0d busy=%b y=%b required gnt=00 sel=0 busy=0 y=0", gnt, sel, busy, y);
        end
        rst = 1'b0;
        req = 8'h00;
        step();
        checks++;
        if ({gnt, busy} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL idle_no_req gnt=%h busy=%b required gnt=00 busy=0", gnt, busy);
        end
    endtask

    task automatic test_first_grant();
        req = 8'b0010_0100;
        din = 8'b0000_0100;
        step();
        checks++;
        if ({gnt, sel, busy, y} !== {8'h04, 3'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL first_grant gnt=%h sel=%0d busy=%b y=%b required gnt=04 sel=2 busy=1 y=1", gnt, sel, busy, y);
        end
    endtask

    task automatic test_handoff();
        req = 8'b0010_0000;
        din = 8'b0010_0000;
        step();
        checks++;
        if ({gnt, sel, busy, y} !== {8'h20, 3'd5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL handoff gnt=%h sel=%0d busy=%b y=%b required gnt=20 sel=5 busy=1 y=1", gnt, sel, busy, y);
        end
        din = 8'b1101_1111;
        #1;
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("FAIL y_tracks_din y=%b required 0", y);
        end
    endtask

    task automatic test_release_idle();
        req = 8'h00;
        din = 8'hff;
        step();
        checks++;
        if ({gnt, sel, busy, y} !== {8'h00, 3'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL release_idle gnt=%h sel=%0d busy=%b y=%b required gnt=00 sel=5 busy=0 y=0", gnt, sel, busy, y);
        end
        // ptr is now 6; the search wraps 6,7,0 and reaches channel 0
        req = 8'h01;
        step();
        checks++;
        if ({gnt, sel, busy} !== {8'h01, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL regrant_ch0 gnt=%h sel=%0d busy=%b required gnt=01 sel=0 busy=1", gnt, sel, busy);
        end
    endtask

    task automatic test_timeout_wrap();
        logic [2:0] exp_sel [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};
        do_reset();
        req = 8'b1000_0001;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({sel, busy, gnt} !== {exp_sel[i], 1'b1, 8'd1 << exp_sel[i]}) begin
                errors++;
                $display("FAIL timeout_wrap[%0d] sel=%0d busy=%b gnt=%h required sel=%0d busy=1", i, sel, busy, gnt, exp_sel[i]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'b0000_1000;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({gnt, sel, busy} !== {8'h08, 3'd3, 1'b1}) begin
                errors++;
                $display("FAIL single_hold[%0d] gnt=%h sel=%0d busy=%b required gnt=08 sel=3 busy=1", i, gnt, sel, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'b0100_0000;
        din = 8'hff;
        step();
        step();
        checks++;
        if ({gnt, sel} !== {8'h40, 3'd6}) begin
            errors++;
            $display("FAIL mid_setup gnt=%h sel=%0d required gnt=40 sel=6", gnt, sel);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({gnt, sel, busy, y} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid gnt=%h sel=%0d busy=%b y=%b required gnt=00 sel=0 busy=0 y=0", gnt, sel, busy, y);
        end
        rst = 1'b0;
        req = 8'b0100_0010;
        step();
        checks++;
        if ({gnt, sel, busy} !== {8'h02, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL after_reset_grant gnt=%h sel=%0d busy=%b required gnt=02 sel=1 busy=1", gnt, sel, busy);
        end
    endtask

    task automatic test_reset_at_timeout();
        do_reset();
        req = 8'b0000_1000;
        repeat (4) step();
        rst = 1'b1;
        step();
        checks++;
        if ({gnt, sel, busy} !== {8'h00, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_at_timeout gnt=%h sel=%0d busy=%b required gnt=00 sel=0 busy=0", gnt, sel, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        // channel 1 releases in the same edge channel 0 rises: search 2..7,0 picks 0
        do_reset();
        req = 8'b0000_0010;
        step();
        req = 8'b0000_0001;
        step();
        checks++;
        if ({gnt, sel, busy} !== {8'h01, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_wrap_search gnt=%h sel=%0d busy=%b required gnt=01 sel=0 busy=1", gnt, sel, busy);
        end
        // channel 7 releases: ptr wraps to 0, so 0 beats 6
        do_reset();
        req = 8'b1000_0000;
        step();
        req = 8'b0100_0001;
        step();
        checks++;
        if ({gnt, sel, busy} !== {8'h01, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL release7_wrap gnt=%h sel=%0d busy=%b required gnt=01 sel=0 busy=1", gnt, sel, busy);
        end
        // timeout with competitor: ch2 holds 4 cycles, then ch5 takes over
        do_reset();
        req = 8'b0010_0100;
        repeat (4) step();
        checks++;
        if (sel !== 3'd2) begin
            errors++;
            $display("FAIL hold_before_timeout sel=%0d required 2", sel);
        end
        step();
        checks++;
        if ({gnt, sel, busy} !== {8'h20, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL timeout_rotate gnt=%h sel=%0d busy=%b required gnt=20 sel=5 busy=1", gnt, sel, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        din = 8'h00;
        test_reset();
        test_first_grant();
        test_handoff();
        test_release_idle();
        test_timeout_wrap();
        test_single();
        test_reset_mid();
        test_reset_at_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux8_arbiter.md
RR_MUX8_ARBITER -- requirements
Module: rr_mux8_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, 4, maximum consecutive grant cycles per owner before forced rotation (legal 1..15).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  8  request per channel i0..i7; bit n SHALL be held high by channel n while it wants the shared mux.
REQ-005 din  input  8  data per channel; bit n is the mux input for channel n.
REQ-006 gnt  output 8  one-hot grant, registered.
REQ-007 sel  output 3  mux select {s2,s1,s0}, registered; equals index of the granted channel.
REQ-008 busy output 1  high while any grant is active, registered.
REQ-009 y    output 1  shared mux output.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no owner) and GRANT (one owner).
REQ-011 Internal state SHALL be: round-robin pointer ptr (3 bits) and hold counter hcnt (4 bits).
REQ-012 Search rule: the winner SHALL be the first channel with req high, scanning ptr, ptr+1, ... up to 7, then wrapping 0 upward, until all 8 channels are checked.
REQ-013 IDLE, req==0: SHALL stay IDLE; gnt, busy and hcnt unchanged (0).
REQ-014 IDLE, req!=0 at edge N: after edge N, gnt=one-hot(winner), sel=winner, busy=1, hcnt=0, state GRANT (1-cycle latency).
REQ-015 GRANT, req[sel]=1, hcnt<MAX_HOLD-1: grant SHALL hold; hcnt increments.
REQ-016 GRANT, req[sel]=0 (release): at that edge ptr=sel+1 mod 8; the search SHALL run from the new ptr in the same edge; any winner SHALL be granted with no dead cycle and hcnt=0; with no winner, state IDLE, gnt=0, busy=0.
REQ-017 GRANT, req[sel]=1, hcnt==MAX_HOLD-1 (timeout): ptr=sel+1 mod 8; search per REQ-012; another requester SHALL win; if none, the same channel is re-granted with hcnt=0.
REQ-018 MAX_HOLD=1 SHALL rotate every cycle among active requesters.
REQ-019 gnt SHALL always be zero or one-hot; when busy=1, gnt[sel]=1.
REQ-020 sel SHALL retain the last granted index while IDLE.
REQ-021 y SHALL equal din[sel] when busy=1 and 0 when busy=0 (combinational from din, sel and busy).
REQ-022 Requests that rise or fall in the same cycle as a release or timeout SHALL be evaluated on their sampled value at that edge only.
REQ-023 Pointer wrap: sel=7 releasing SHALL set ptr=0.

Reset
REQ-024 rst=1 at an edge SHALL force, after that edge: state IDLE, gnt=0, sel=0, busy=0, ptr=0, hcnt=0; y=0 follows.
REQ-025 rst SHALL override every other condition, including mid-grant and at timeout.
REQ-026 The first grant after reset SHALL resolve from channel 0 upward.

Verification
REQ-027 After reset, req=8'b0010_0100 -> one edge later gnt=8'b0000_0100, sel=2, busy=1; din[2]=1 -> y=1.
REQ-028 req[2] dropped while req[5] held -> next edge gnt=8'b0010_0000, sel=5, with no busy=0 cycle; y tracks din[5].
REQ-029 MAX_HOLD=4, req=8'b1000_0001 held continuously -> sel sequence 0,0,0,0,7,7,7,7,0,... demonstrating timeout and 7->0 wrap.
REQ-030 Single requester req=8'b0000_1000 held, MAX_HOLD=4 -> gnt stays 8'b0000_1000 continuously, hcnt reloads, busy never drops.
REQ-031 rst asserted for one edge mid-grant (sel=6) -> gnt=0, sel=0, busy=0, y=0; then req=8'b0100_0010 -> grant goes to channel 1.
REQ-032 All req dropped during GRANT -> next edge busy=0, gnt=0, y=0, sel retains the last value; a new req=8'b0000_0001 grants channel 0 only if ptr search reaches it first.
